regfile_wb_arb: RTL

// Write-port arbiter and sequencer for the single-write-port register file.
// Two writeback sources compete for the port: the ALU/execute result and the memory/load result.
// The block grants one source per cycle and registers the winning write onto rf_wen/rf_waddr/rf_wdata.

---
 rtl/regfile_wb_arb_if.sv | 32 +++
 rtl/regfile_wb_arb.sv | 73 +++++++
 2 files changed

// File: rtl/regfile_wb_arb_if.sv
// Writeback bus between the ALU/load sources, the write-port arbiter and the register file.
interface regfile_wb_arb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              starved;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  rf_wen, rf_waddr, rf_wdata, starved
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output rf_wen, rf_waddr, rf_wdata, starved
  );
endinterface

// File: rtl/regfile_wb_arb.sv
// Single write-port arbiter: loads win over ALU results, except when the ALU has been
// denied STARVE_LIMIT times in a row. The winning write is registered onto the RF port.
module regfile_wb_arb #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  regfile_wb_arb_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              starved;
  logic              grant_mem;
  logic              grant_alu;

  assign starved = (starve_cnt_q == CNT_MAX);

  // Grant stage: combinational ready from the valids and the starvation state
  always_comb begin
    grant_mem = bus.mem_valid && !(bus.alu_valid && starved);
    grant_alu = bus.alu_valid && !grant_mem;
  end

  always_comb begin
    starve_cnt_d = '0;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;

    if (bus.alu_valid && !grant_alu)
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + CNT_W'(1);

    // Writes to x0 are acknowledged but never reach the register file
    if (grant_mem) begin
      rf_wen_d   = (bus.mem_addr != '0);
      rf_waddr_d = bus.mem_addr;
      rf_wdata_d = bus.mem_data;
    end else if (grant_alu) begin
      rf_wen_d   = (bus.alu_addr != '0);
      rf_waddr_d = bus.alu_addr;
      rf_wdata_d = bus.alu_data;
    end
  end

  // Write stage: registered RF port, one cycle after acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= '0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.starved   = starved;
endmodule
